fetch_unit: RTL

- Instruction-fetch stage feeding the decode stage.
- Consumes the branch and flush outputs of the execution stage: take_branch, flush_pipeline, and the redirect target PC.
- Generates sequential Thumb fetch addresses and issues pipelined requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake; discards wrong-path data after a redirect.

---
 rtl/fetch_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding decode.
// Issues sequential Thumb fetch requests over a req/gnt/rvalid handshake,
// buffers responses in a small FIFO and presents them to decode with
// valid/ready. A branch or flush from execute redirects fetch and discards
// every response that was already in flight (drained in state DRAIN).
//
// Ports:
//   clk_i, reset_i              clock, synchronous active-high reset
//   take_branch_i               redirect fetch to branch_target_i (active value TAKE_BRANCH = 1)
//   flush_pipeline_i            discard buffered/in-flight data (active value FLUSH_PIPELINE = 1)
//   branch_target_i             redirect address (bit 0 cleared on a taken branch)
//   imem_req_o/addr_o/gnt_i     request channel to instruction memory
//   imem_rvalid_i/rdata_i       in-order response channel
//   decode_ready_i              decode accepts the head instruction
//   is_valid_o                  instruction_o / program_counter_o valid
//   instruction_o               head-of-FIFO instruction
//   program_counter_o           fetch address of instruction_o + 4
// Optional feature, macro FETCH_PERF_CNT_EN:
//   redirect_count_o, starve_count_o  saturating 32-bit performance counters
module fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned INSTR_WIDTH = 16
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   take_branch_i,
   input  logic                   flush_pipeline_i,
   input  logic [31:0]            branch_target_i,
   output logic                   imem_req_o,
   output logic [31:0]            imem_addr_o,
   input  logic                   imem_gnt_i,
   input  logic                   imem_rvalid_i,
   input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
   input  logic                   decode_ready_i,
   output logic                   is_valid_o,
   output logic [INSTR_WIDTH-1:0] instruction_o,
   output logic [31:0]            program_counter_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]            redirect_count_o,
   output logic [31:0]            starve_count_o
`endif
);

   localparam int unsigned WORD_W = 32;
   localparam int unsigned IDX_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned PTR_W  = IDX_W + 1;
   localparam int unsigned SUM_W  = PTR_W + 1;
   localparam logic [WORD_W-1:0] PC_STEP = WORD_W'(INSTR_WIDTH / 8);
   localparam logic TAKE_BRANCH    = 1'b1;
   localparam logic FLUSH_PIPELINE = 1'b1;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } state_e;

   state_e                 state_q;
   logic [WORD_W-1:0]      fetch_pc_q;
   logic [WORD_W-1:0]      rsp_pc_q;
   logic [PTR_W-1:0]       outstanding_q;
   logic [PTR_W-1:0]       drop_cnt_q;
   logic [PTR_W-1:0]       wr_ptr_q;
   logic [PTR_W-1:0]       rd_ptr_q;
   logic [INSTR_WIDTH-1:0] fifo_instr [FIFO_DEPTH];
   logic [WORD_W-1:0]      fifo_pc    [FIFO_DEPTH];

   logic                   redirect;
   logic                   branch_taken;
   logic [WORD_W-1:0]      target;
   logic [PTR_W-1:0]       fifo_count;
   logic                   credit_ok;
   logic                   fire;
   logic                   drop_rsp;
   logic                   push;
   logic                   pop;
   logic [PTR_W-1:0]       outstanding_next;
   logic [IDX_W-1:0]       rd_idx;
   logic [IDX_W-1:0]       wr_idx;

   // Redirect decode; a flush alone takes exec's recovery PC unmodified.
   assign branch_taken = (take_branch_i == TAKE_BRANCH);
   assign redirect     = branch_taken || (flush_pipeline_i == FLUSH_PIPELINE);
   assign target       = branch_taken ? {branch_target_i[WORD_W-1:1], 1'b0}
                                      : branch_target_i;

   // Credit: buffered plus in-flight never exceeds FIFO capacity.
   assign fifo_count = wr_ptr_q - rd_ptr_q;
   assign credit_ok  = (SUM_W'(fifo_count) + SUM_W'(outstanding_q)) < SUM_W'(FIFO_DEPTH);

   assign imem_req_o  = !reset_i && (state_q == RUN) && !redirect && credit_ok;
   assign imem_addr_o = fetch_pc_q;
   assign fire        = imem_req_o && imem_gnt_i;

   // Responses are dropped while drop_cnt is non-zero; any response arriving
   // in a redirect cycle belongs to the old path and is discarded too.
   assign drop_rsp = imem_rvalid_i && (drop_cnt_q != '0);
   assign push     = imem_rvalid_i && (drop_cnt_q == '0) && !redirect;
   assign pop      = is_valid_o && decode_ready_i && !redirect;

   assign outstanding_next = outstanding_q + PTR_W'(fire) - PTR_W'(imem_rvalid_i);

   assign rd_idx = rd_ptr_q[IDX_W-1:0];
   assign wr_idx = wr_ptr_q[IDX_W-1:0];

   // Decode-side view of the FIFO head; zero while empty.
   assign is_valid_o        = (wr_ptr_q != rd_ptr_q);
   assign instruction_o     = is_valid_o ? fifo_instr[rd_idx] : '0;
   assign program_counter_o = is_valid_o ? (fifo_pc[rd_idx] + 32'd4) : '0;

   // Fetch FSM, request/response bookkeeping and FIFO storage.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= RUN;
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
      end else begin
         outstanding_q <= outstanding_next;
         if (redirect) begin
            // Everything still in flight after this cycle is wrong-path.
            fetch_pc_q <= target;
            rsp_pc_q   <= target;
            drop_cnt_q <= outstanding_next;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= (outstanding_next != '0) ? DRAIN : RUN;
         end else begin
            if (fire) begin
               fetch_pc_q <= fetch_pc_q + PC_STEP;
            end
            if (drop_rsp) begin
               drop_cnt_q <= drop_cnt_q - PTR_W'(1);
               if (state_q == DRAIN && drop_cnt_q == PTR_W'(1)) begin
                  state_q <= RUN;
               end
            end
            if (push) begin
               fifo_instr[wr_idx] <= imem_rdata_i;
               fifo_pc[wr_idx]    <= rsp_pc_q;
               wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
               rsp_pc_q           <= rsp_pc_q + PC_STEP;
            end
            if (pop) begin
               rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // Saturating redirect and decode-starvation counters.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         redirect_count_o <= '0;
         starve_count_o   <= '0;
      end else begin
         if (redirect && (redirect_count_o != '1)) begin
            redirect_count_o <= redirect_count_o + 32'd1;
         end
         if (decode_ready_i && !is_valid_o && (starve_count_o != '1)) begin
            starve_count_o <= starve_count_o + 32'd1;
         end
      end
   end
`endif

endmodule
